cond_flag_unit: RTL and testbench

Condition-code unit for the pipelined ARM core: the consumer end of the flag path. Holds the architectural NZCV flags written by flag-setting instructions leaving EX. Evaluates the 4-bit ARM condition field of the instruction in the ID/EX stage against those flags, with same-cycle forwarding. On a taken branch, runs a small flush sequencer that squashes the instructions in the branch shadow.

---
 rtl/cond_pkg.sv | 29 ++
 rtl/cond_eval.sv | 36 +++
 rtl/cond_flag_unit.sv | 118 +++++++++++
 tb/tb_cond_flag_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition-code constants, state encoding and counter width
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flush counter width; supports FLUSH_CYCLES up to 7
    localparam int CNT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-field evaluator
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    output logic       pass
);

    // Decode the 4-bit condition against the supplied flags; 1111 never passes
    always_comb begin
        pass = 1'b0;
        case (Cond)
            COND_EQ: pass = Z;
            COND_NE: pass = !Z;
            COND_CS: pass = C;
            COND_CC: pass = !C;
            COND_MI: pass = N;
            COND_PL: pass = !N;
            COND_VS: pass = V;
            COND_VC: pass = !V;
            COND_HI: pass = C & !Z;
            COND_LS: pass = !C | Z;
            COND_GE: pass = (N == V);
            COND_LT: pass = (N != V);
            COND_GT: pass = !Z & (N == V);
            COND_LE: pass = Z | (N != V);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register, condition check with bypass, branch flush sequencer
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Cond,
    input  logic       CondValid,
    input  logic       IsBranch,
    input  logic       SetFlags,
    input  logic       Nin,
    input  logic       Zin,
    input  logic       Cin,
    input  logic       Vin,
    output logic       N,
    output logic       Z,
    output logic       C,
    output logic       V,
    output logic       CondPass,
    output logic       BranchTaken,
    output logic       Flush
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             branch_taken_q;
    logic             flush_q;

    logic             idle;
    logic             flag_write;
    logic [3:0]       eval_flags;
    logic             eval_pass;
    logic             take_branch;

    assign idle       = (state_q == ST_IDLE);
    // A flag setter arriving during a flush is in the squashed shadow
    assign flag_write = SetFlags & idle;

    // Flag source: same-cycle ALU result when it is being written, else stored flags
    always_comb begin
        eval_flags = flags_q;
        flags_d    = flags_q;
        if (flag_write) begin
            eval_flags = {Nin, Zin, Cin, Vin};
            flags_d    = {Nin, Zin, Cin, Vin};
        end
    end

    cond_eval u_cond_eval (
        .Cond (Cond),
        .N    (eval_flags[3]),
        .Z    (eval_flags[2]),
        .C    (eval_flags[1]),
        .V    (eval_flags[0]),
        .pass (eval_pass)
    );

    assign CondPass    = CondValid & eval_pass & idle;
    assign take_branch = CondPass & IsBranch;

    // Architectural flag register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Flush sequencer: taken branch holds Flush for FLUSH_CYCLES cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            branch_taken_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    branch_taken_q <= take_branch;
                    flush_q        <= take_branch;
                    if (take_branch) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    branch_taken_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    cnt_q          <= '0;
                    branch_taken_q <= 1'b0;
                    flush_q        <= 1'b0;
                end
            endcase
        end
    end

    assign N           = flags_q[3];
    assign Z           = flags_q[2];
    assign C           = flags_q[1];
    assign V           = flags_q[0];
    assign BranchTaken = branch_taken_q;
    assign Flush       = flush_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - directed self-checking bench for cond_flag_unit
module tb_cond_flag_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Cond;
    logic       CondValid;
    logic       IsBranch;
    logic       SetFlags;
    logic       Nin, Zin, Cin, Vin;
    logic       N, Z, C, V, CondPass, BranchTaken, Flush;
    logic       N1, Z1, C1, V1, CondPass1, BranchTaken1, Flush1;

    int checks   = 0;
    int failures = 0;

    // Hand-computed truth masks: bit index = {N,Z,C,V}
    logic [15:0] pass_mask [16];

    cond_flag_unit #(.FLUSH_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Cond(Cond), .CondValid(CondValid),
        .IsBranch(IsBranch), .SetFlags(SetFlags),
        .Nin(Nin), .Zin(Zin), .Cin(Cin), .Vin(Vin),
        .N(N), .Z(Z), .C(C), .V(V), .CondPass(CondPass),
        .BranchTaken(BranchTaken), .Flush(Flush)
    );

    cond_flag_unit #(.FLUSH_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Cond(Cond), .CondValid(CondValid),
        .IsBranch(IsBranch), .SetFlags(SetFlags),
        .Nin(Nin), .Zin(Zin), .Cin(Cin), .Vin(Vin),
        .N(N1), .Z(Z1), .C(C1), .V(V1), .CondPass(CondPass1),
        .BranchTaken(BranchTaken1), .Flush(Flush1)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = 4'h0; CondValid = 1'b0; IsBranch = 1'b0; SetFlags = 1'b0;
        Nin = 1'b0; Zin = 1'b0; Cin = 1'b0; Vin = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] nzcv);
        SetFlags = 1'b1;
        {Nin, Zin, Cin, Vin} = nzcv;
        tick();
        SetFlags = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({N, Z, C, V, BranchTaken, Flush} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=000000", {N, Z, C, V, BranchTaken, Flush});
        end
    endtask

    task automatic test_flag_load();
        load_flags(4'b1010);
        checks++;
        if ({N, Z, C, V} !== 4'b1010) begin
            failures++;
            $display("FAIL flag_load got=%b want=1010", {N, Z, C, V});
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({N, Z, C, V} !== 4'b0000) begin
            failures++;
            $display("FAIL flag_reset got=%b want=0000", {N, Z, C, V});
        end
    endtask

    task automatic test_eq_ne();
        load_flags(4'b0100);
        CondValid = 1'b1;
        Cond = 4'h0; #1;
        checks++;
        if (CondPass !== 1'b1) begin
            failures++; $display("FAIL eq_z1 got=%b want=1", CondPass);
        end
        Cond = 4'h1; #1;
        checks++;
        if (CondPass !== 1'b0) begin
            failures++; $display("FAIL ne_z1 got=%b want=0", CondPass);
        end
        Cond = 4'hF; #1;
        checks++;
        if (CondPass !== 1'b0) begin
            failures++; $display("FAIL nv_never got=%b want=0", CondPass);
        end
        CondValid = 1'b0; Cond = 4'hE; IsBranch = 1'b1; #1;
        checks++;
        if (CondPass !== 1'b0) begin
            failures++; $display("FAIL invalid_cond got=%b want=0", CondPass);
        end
        tick();
        checks++;
        if ({BranchTaken, Flush} !== 2'b00) begin
            failures++; $display("FAIL invalid_no_branch got=%b want=00", {BranchTaken, Flush});
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            CondValid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                checks++;
                if (CondPass !== pass_mask[c][f]) begin
                    failures++;
                    $display("FAIL sweep cond=%h nzcv=%b got=%b want=%b", c[3:0], f[3:0], CondPass, pass_mask[c][f]);
                end
            end
            CondValid = 1'b0;
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_bypass();
        load_flags(4'b0000);
        SetFlags = 1'b1; Zin = 1'b1;
        Cond = 4'h0; CondValid = 1'b1; IsBranch = 1'b1;
        #1;
        checks++;
        if (CondPass !== 1'b1) begin
            failures++; $display("FAIL bypass_pass got=%b want=1", CondPass);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({BranchTaken, Flush, Z} !== 3'b111) begin
            failures++; $display("FAIL bypass_branch got=%b want=111", {BranchTaken, Flush, Z});
        end
        tick();
        checks++;
        if ({BranchTaken, Flush} !== 2'b01) begin
            failures++; $display("FAIL bypass_flush2 got=%b want=01", {BranchTaken, Flush});
        end
        tick();
        checks++;
        if (Flush !== 1'b0) begin
            failures++; $display("FAIL bypass_flush_end got=%b want=0", Flush);
        end
    endtask

    task automatic test_flush_seq();
        // Flags are 0100 here
        Cond = 4'hE; CondValid = 1'b1; IsBranch = 1'b1;
        #1;
        checks++;
        if (CondPass !== 1'b1) begin
            failures++; $display("FAIL flush_t_pass got=%b want=1", CondPass);
        end
        tick();
        SetFlags = 1'b1; {Nin, Zin, Cin, Vin} = 4'b1011;
        #1;
        checks++;
        if ({CondPass, BranchTaken, Flush} !== 3'b011) begin
            failures++; $display("FAIL flush_t1 got=%b want=011", {CondPass, BranchTaken, Flush});
        end
        tick();
        checks++;
        if ({BranchTaken, Flush, N, Z, C, V} !== 6'b010100) begin
            failures++; $display("FAIL flush_t2 got=%b want=010100", {BranchTaken, Flush, N, Z, C, V});
        end
        idle_inputs();
        tick();
        checks++;
        if ({BranchTaken, Flush, N, Z, C, V} !== 6'b000100) begin
            failures++; $display("FAIL flush_t3 got=%b want=000100", {BranchTaken, Flush, N, Z, C, V});
        end
    endtask

    task automatic test_flush_one();
        Cond = 4'hE; CondValid = 1'b1; IsBranch = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({BranchTaken1, Flush1} !== 2'b11) begin
            failures++; $display("FAIL one_cycle_t1 got=%b want=11", {BranchTaken1, Flush1});
        end
        tick();
        checks++;
        if ({BranchTaken1, Flush1, Flush} !== 3'b001) begin
            failures++; $display("FAIL one_cycle_t2 got=%b want=001", {BranchTaken1, Flush1, Flush});
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        Cond = 4'hE; CondValid = 1'b1; IsBranch = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (Flush !== 1'b1) begin
            failures++; $display("FAIL midrst_t1 got=%b want=1", Flush);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({BranchTaken, Flush, N, Z, C, V} !== 6'b000000) begin
            failures++; $display("FAIL midrst_t2 got=%b want=000000", {BranchTaken, Flush, N, Z, C, V});
        end
        Cond = 4'h1; CondValid = 1'b1; IsBranch = 1'b1;
        #1;
        checks++;
        if (CondPass !== 1'b1) begin
            failures++; $display("FAIL midrst_eval got=%b want=1", CondPass);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({BranchTaken, Flush} !== 2'b11) begin
            failures++; $display("FAIL midrst_branch got=%b want=11", {BranchTaken, Flush});
        end
        tick(); tick();
    endtask

    initial begin
        pass_mask[0]  = 16'hF0F0; pass_mask[1]  = 16'h0F0F;
        pass_mask[2]  = 16'hCCCC; pass_mask[3]  = 16'h3333;
        pass_mask[4]  = 16'hFF00; pass_mask[5]  = 16'h00FF;
        pass_mask[6]  = 16'hAAAA; pass_mask[7]  = 16'h5555;
        pass_mask[8]  = 16'h0C0C; pass_mask[9]  = 16'hF3F3;
        pass_mask[10] = 16'hAA55; pass_mask[11] = 16'h55AA;
        pass_mask[12] = 16'h0A05; pass_mask[13] = 16'hF5FA;
        pass_mask[14] = 16'hFFFF; pass_mask[15] = 16'h0000;
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_flag_load();
        test_eq_ne();
        test_sweep();
        test_bypass();
        test_flush_seq();
        test_flush_one();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
